// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 core arbiter.
//   ShaContext : running hash context handed to the transform core with each chunk.
//   CTX_W      : packed width of ShaContext.
//   CHUNK_W    : message chunk width (16 x 32-bit words).
//   HASH_W     : transform result width.
//   ArbState   : arbiter job-sequencing states.
package sha256_pkg;

  localparam int unsigned CHUNK_W = 512;
  localparam int unsigned HASH_W  = 256;

  typedef struct packed {
    logic [255:0] h;       // intermediate hash words H0..H7
    logic [63:0]  bitlen;  // message bits already absorbed
    logic [31:0]  curlen;  // bytes valid in the current chunk
  } ShaContext;

  localparam int unsigned CTX_W = $bits(ShaContext);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESP
  } ArbState;

endpackage

// File: rtl/sha256_arbiter_rr_picker.sv
// Combinational round-robin search, reusable for any shared resource.
// Ports:
//   req_vld_i : request vector.
//   rr_ptr_i  : index of the last winner; search starts at rr_ptr_i + 1 and wraps.
//   winner_o  : index of the first requester found (0 when none).
//   any_o     : at least one request is present.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vld_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_o
);

  int unsigned idx;

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    // Offsets 1..NUM_REQ so the previous winner is considered last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ({{(32 - ID_W){1'b0}}, rr_ptr_i} + k) % NUM_REQ;
      if (!any_o && req_vld_i[idx[ID_W-1:0]]) begin
        any_o    = 1'b1;
        winner_o = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sha256_arbiter.sv
// Shares one SHA-256 transform core among NUM_REQ requesters, one job in flight.
// A job (context + 512-bit chunk) is latched at grant, pushed to the core over two
// independent valid/ready channels, and the returned hash is presented only to the
// requester that owns it.
// Ports:
//   clk, rst             : clock; synchronous active-high reset (shared with the core).
//   req_vld/rdy/ctx/chunk: per-requester job inputs; req_rdy is one-hot or zero.
//   core_ctx_*, core_chunk_*: latched job towards the core.
//   core_hash_*          : result from the core.
//   rsp_vld/rdy          : one-hot response handshake; rsp_hash/rsp_id shared bus.
//   perf_jobs, perf_busy : saturating counters, only with SHA256_ARB_PERF_EN defined.
module sha256_arbiter
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_rdy,
  input  ShaContext [NUM_REQ-1:0]         req_ctx,
  input  logic [NUM_REQ-1:0][CHUNK_W-1:0] req_chunk,
  output logic                            core_ctx_vld,
  input  logic                            core_ctx_rdy,
  output ShaContext                       core_ctx,
  output logic                            core_chunk_vld,
  input  logic                            core_chunk_rdy,
  output logic [CHUNK_W-1:0]              core_chunk,
  input  logic                            core_hash_vld,
  output logic                            core_hash_rdy,
  input  logic [HASH_W-1:0]               core_hash,
  output logic [NUM_REQ-1:0]              rsp_vld,
  input  logic [NUM_REQ-1:0]              rsp_rdy,
  output logic [HASH_W-1:0]               rsp_hash,
  output logic [ID_W-1:0]                 rsp_id
`ifdef SHA256_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_jobs,
  output logic [31:0]                     perf_busy
`endif
);

  ArbState              state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  ShaContext            ctx_q, ctx_d;
  logic [CHUNK_W-1:0]   chunk_q, chunk_d;
  logic [HASH_W-1:0]    hash_q, hash_d;
  logic                 ctx_sent_q, ctx_sent_d;
  logic                 chunk_sent_q, chunk_sent_d;

  logic [ID_W-1:0]      winner;
  logic                 any_vld;
  logic                 ctx_done;
  logic                 chunk_done;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_vld_i (req_vld),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_o     (any_vld)
  );

  // In SEND a channel's vld is !sent, so "sent or ready" means done by the next edge.
  assign ctx_done   = ctx_sent_q   | core_ctx_rdy;
  assign chunk_done = chunk_sent_q | core_chunk_rdy;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    rsp_id_d       = rsp_id_q;
    ctx_d          = ctx_q;
    chunk_d        = chunk_q;
    hash_d         = hash_q;
    ctx_sent_d     = ctx_sent_q;
    chunk_sent_d   = chunk_sent_q;
    req_rdy        = '0;
    core_ctx_vld   = 1'b0;
    core_chunk_vld = 1'b0;
    core_hash_rdy  = 1'b0;
    rsp_vld        = '0;

    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          req_rdy[winner] = 1'b1;
          ctx_d           = req_ctx[winner];
          chunk_d         = req_chunk[winner];
          grant_d         = winner;
          rr_ptr_d        = winner;
          state_d         = SEND;
        end
      end
      SEND: begin
        core_ctx_vld   = !ctx_sent_q;
        core_chunk_vld = !chunk_sent_q;
        if (ctx_done && chunk_done) begin
          ctx_sent_d   = 1'b0;
          chunk_sent_d = 1'b0;
          state_d      = WAIT;
        end else begin
          ctx_sent_d   = ctx_done;
          chunk_sent_d = chunk_done;
        end
      end
      WAIT: begin
        core_hash_rdy = 1'b1;
        if (core_hash_vld) begin
          hash_d   = core_hash;
          rsp_id_d = grant_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp_vld[grant_q] = 1'b1;
        // Return to IDLE without granting: guarantees one idle cycle between jobs.
        if (rsp_rdy[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      grant_q      <= '0;
      rsp_id_q     <= '0;
      ctx_q        <= '0;
      chunk_q      <= '0;
      hash_q       <= '0;
      ctx_sent_q   <= 1'b0;
      chunk_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      rsp_id_q     <= rsp_id_d;
      ctx_q        <= ctx_d;
      chunk_q      <= chunk_d;
      hash_q       <= hash_d;
      ctx_sent_q   <= ctx_sent_d;
      chunk_sent_q <= chunk_sent_d;
    end
  end

  assign core_ctx   = ctx_q;
  assign core_chunk = chunk_q;
  assign rsp_hash   = hash_q;
  assign rsp_id     = rsp_id_q;

`ifdef SHA256_ARB_PERF_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_jobs_d = perf_jobs_q;
    perf_busy_d = perf_busy_q;
    if (state_q == RESP && rsp_rdy[grant_q] && perf_jobs_q != '1) begin
      perf_jobs_d = perf_jobs_q + 32'd1;
    end
    if (state_q != IDLE && perf_busy_q != '1) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs_q <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_jobs_q <= perf_jobs_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_jobs = perf_jobs_q;
  assign perf_busy = perf_busy_q;
`endif

endmodule
